// File: rtl/decode_out_recorder.sv
// rtl/decode_out_recorder.sv - decode-stage output trace recorder with filtered capture and show-ahead FIFO
module decode_out_recorder #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int TS_W   = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [1:0]                    W_control,
  input  logic                          Mem_control,
  input  logic [5:0]                    E_control,
  input  logic [DATA_W-1:0]             IR,
  input  logic [DATA_W-1:0]             npc_out,
  input  logic                          in_valid,
  input  logic [1:0]                    cfg_mode,
  input  logic [3:0]                    cfg_opcode,
  input  logic                          clear,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [TS_W+9+2*DATA_W-1:0]    out_record,
  output logic [$clog2(DEPTH):0]        count,
  output logic [7:0]                    overflow_cnt
);

  localparam int BUNDLE_W = 9 + 2 * DATA_W;
  localparam int REC_W    = TS_W + BUNDLE_W;
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = PTR_W + 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [7:0]       OVF_MAX  = 8'hFF;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_ALL    = 2'd1,
    MODE_CHANGE = 2'd2,
    MODE_MATCH  = 2'd3
  } mode_e;

  mode_e                mode;
  logic [BUNDLE_W-1:0]  bundle;
  logic [REC_W-1:0]     rec_in;

  logic [TS_W-1:0]      ts_q;
  logic [BUNDLE_W-1:0]  last_q;
  logic                 have_last_q;

  logic [REC_W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic [7:0]           ovf_q;

  logic                 full;
  logic                 empty;
  logic                 qualify;
  logic                 pop;
  logic                 push;
  logic                 drop;
  logic                 push_en;
  logic                 pop_en;

  assign mode   = mode_e'(cfg_mode);
  assign bundle = {W_control, Mem_control, E_control, IR, npc_out};
  assign rec_in = {ts_q, bundle};

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Decide whether the sampled bundle is worth recording under the current mode
  always_comb begin
    qualify = 1'b0;
    if (in_valid) begin
      case (mode)
        MODE_OFF:    qualify = 1'b0;
        MODE_ALL:    qualify = 1'b1;
        MODE_CHANGE: qualify = !have_last_q || (bundle != last_q);
        MODE_MATCH:  qualify = (IR[DATA_W-1 -: 4] == cfg_opcode);
        default:     qualify = 1'b0;
      endcase
    end
  end

  // A full FIFO still accepts a sample when the head leaves in the same cycle
  always_comb begin
    pop     = !empty && out_ready;
    push    = qualify && (!full || pop);
    drop    = qualify && full && !pop;
    push_en = push && !clear;
    pop_en  = pop && !clear;
  end

  // Free-running timestamp, restarted by clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ts_q <= '0;
    end else if (clear) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
    end
  end

  // Remember the most recently stored bundle for change detection
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_q      <= '0;
      have_last_q <= 1'b0;
    end else if (clear) begin
      have_last_q <= 1'b0;
    end else if (push_en) begin
      last_q      <= bundle;
      have_last_q <= 1'b1;
    end
  end

  // Record storage; contents are only meaningful below the count, so no reset
  always_ff @(posedge clock) begin
    if (push_en) begin
      mem[wr_ptr_q] <= rec_in;
    end
  end

  // Write and read pointers, wrapping naturally at the power-of-two depth
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_en) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_en) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Occupancy: simultaneous push and pop leaves it unchanged
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else begin
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Saturating count of qualifying samples lost to a full FIFO
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf_q <= '0;
    end else if (clear) begin
      ovf_q <= '0;
    end else if (drop && (ovf_q != OVF_MAX)) begin
      ovf_q <= ovf_q + 8'd1;
    end
  end

  // Show-ahead head record; forced to zero when nothing is held
  always_comb begin
    out_valid  = !empty;
    out_record = '0;
    if (!empty) begin
      out_record = mem[rd_ptr_q];
    end
  end

  assign count        = count_q;
  assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_decode_out_recorder.sv
// tb/tb_decode_out_recorder.sv - randomized and directed bench for decode_out_recorder against a queue model
module tb_decode_out_recorder;

  localparam int DATA_W   = 16;
  localparam int DEPTH    = 8;
  localparam int TS_W     = 16;
  localparam int BUNDLE_W = 9 + 2 * DATA_W;
  localparam int REC_W    = TS_W + BUNDLE_W;
  localparam int CNT_W    = $clog2(DEPTH) + 1;

  logic                clock;
  logic                reset;
  logic [1:0]          W_control;
  logic                Mem_control;
  logic [5:0]          E_control;
  logic [DATA_W-1:0]   IR;
  logic [DATA_W-1:0]   npc_out;
  logic                in_valid;
  logic [1:0]          cfg_mode;
  logic [3:0]          cfg_opcode;
  logic                clear;
  logic                out_valid;
  logic                out_ready;
  logic [REC_W-1:0]    out_record;
  logic [CNT_W-1:0]    count;
  logic [7:0]          overflow_cnt;

  int checks = 0;
  int errors = 0;

  logic [REC_W-1:0]    m_q[$];
  logic [REC_W-1:0]    got[$];
  logic [TS_W-1:0]     m_ts;
  logic [BUNDLE_W-1:0] m_last;
  bit                  m_have;
  int                  m_ovf;
  int                  peak;

  decode_out_recorder #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .TS_W  (TS_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .W_control   (W_control),
    .Mem_control (Mem_control),
    .E_control   (E_control),
    .IR          (IR),
    .npc_out     (npc_out),
    .in_valid    (in_valid),
    .cfg_mode    (cfg_mode),
    .cfg_opcode  (cfg_opcode),
    .clear       (clear),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_record  (out_record),
    .count       (count),
    .overflow_cnt(overflow_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_reset();
    m_q.delete();
    m_ts   = '0;
    m_last = '0;
    m_have = 1'b0;
    m_ovf  = 0;
  endtask

  task automatic idle_inputs();
    W_control   = '0;
    Mem_control = 1'b0;
    E_control   = '0;
    IR          = '0;
    npc_out     = '0;
    in_valid    = 1'b0;
    cfg_mode    = 2'd0;
    cfg_opcode  = 4'd0;
    clear       = 1'b0;
    out_ready   = 1'b0;
  endtask

  // Assert reset across two edges and release it just after a rising edge
  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
    got.delete();
    peak = 0;
  endtask

  // One clock: log the accepted head, advance the model from the spec rules
  task automatic cycle();
    logic [BUNDLE_W-1:0] b;
    bit qual, pop, full, clr;
    if (out_valid && out_ready) got.push_back(out_record);
    b    = {W_control, Mem_control, E_control, IR, npc_out};
    clr  = clear;
    pop  = (m_q.size() != 0) && out_ready;
    full = (m_q.size() == DEPTH);
    qual = 1'b0;
    if (in_valid) begin
      case (cfg_mode)
        2'd1:    qual = 1'b1;
        2'd2:    qual = !m_have || (b != m_last);
        2'd3:    qual = (IR[DATA_W-1 -: 4] == cfg_opcode);
        default: qual = 1'b0;
      endcase
    end
    @(posedge clock);
    #1;
    if (clr) begin
      m_q.delete();
      m_ovf  = 0;
      m_ts   = '0;
      m_have = 1'b0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (qual && (!full || pop)) begin
        m_q.push_back({m_ts, b});
        m_last = b;
        m_have = 1'b1;
      end else if (qual) begin
        if (m_ovf < 255) m_ovf++;
      end
      m_ts = m_ts + 1'b1;
    end
    if (int'(count) > peak) peak = int'(count);
  endtask

  function automatic logic [TS_W-1:0] rec_ts(input logic [REC_W-1:0] r);
    return r[REC_W-1 -: TS_W];
  endfunction

  function automatic logic [DATA_W-1:0] rec_ir(input logic [REC_W-1:0] r);
    return r[2*DATA_W-1 -: DATA_W];
  endfunction

  task automatic test_reset();
    idle_inputs();
    do_reset();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++;
    if (count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++;
    if (overflow_cnt !== 8'd0) begin errors++; $display("FAIL reset_overflow got %0d want 0", overflow_cnt); end
    checks++;
    if (out_record !== '0) begin errors++; $display("FAIL reset_record got %h want 0", out_record); end
    repeat (3) cycle();
    checks++;
    if (count !== '0) begin errors++; $display("FAIL reset_idle_count got %0d want 0", count); end
  endtask

  task automatic test_mode_all();
    logic [DATA_W-1:0] exp_ir[3] = '{16'h1234, 16'h5678, 16'h9ABC};
    logic [REC_W-1:0] r;
    idle_inputs();
    do_reset();
    cfg_mode  = 2'd1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      IR = exp_ir[i];
      cycle();
    end
    in_valid = 1'b0;
    repeat (3) cycle();
    checks++;
    if (got.size() != 3) begin errors++; $display("FAIL mode1_records got %0d want 3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      r = (i < got.size()) ? got[i] : '0;
      checks++;
      if (rec_ts(r) !== TS_W'(i)) begin errors++; $display("FAIL mode1_ts[%0d] got %0d want %0d", i, rec_ts(r), i); end
      checks++;
      if (rec_ir(r) !== exp_ir[i]) begin errors++; $display("FAIL mode1_ir[%0d] got %h want %h", i, rec_ir(r), exp_ir[i]); end
    end
    checks++;
    if (peak != 1) begin errors++; $display("FAIL mode1_peak_count got %0d want 1", peak); end
  endtask

  task automatic test_mode_change();
    logic [REC_W-1:0] r0, r1;
    idle_inputs();
    do_reset();
    cfg_mode  = 2'd2;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    IR        = 16'h3000;
    repeat (5) cycle();
    IR = 16'h3001;
    cycle();
    in_valid = 1'b0;
    repeat (3) cycle();
    r0 = (got.size() > 0) ? got[0] : '0;
    r1 = (got.size() > 1) ? got[1] : '0;
    checks++;
    if (got.size() != 2) begin errors++; $display("FAIL mode2_records got %0d want 2", got.size()); end
    checks++;
    if (rec_ts(r0) !== 16'd0 || rec_ir(r0) !== 16'h3000) begin errors++; $display("FAIL mode2_first got ts %0d ir %h want ts 0 ir 3000", rec_ts(r0), rec_ir(r0)); end
    checks++;
    if (rec_ts(r1) !== 16'd5 || rec_ir(r1) !== 16'h3001) begin errors++; $display("FAIL mode2_second got ts %0d ir %h want ts 5 ir 3001", rec_ts(r1), rec_ir(r1)); end
  endtask

  task automatic test_mode_match();
    logic [DATA_W-1:0] stim[3] = '{16'h6001, 16'h1002, 16'h6ABC};
    logic [REC_W-1:0] r0, r1;
    idle_inputs();
    do_reset();
    cfg_mode   = 2'd3;
    cfg_opcode = 4'h6;
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      IR = stim[i];
      cycle();
    end
    in_valid = 1'b0;
    repeat (3) cycle();
    r0 = (got.size() > 0) ? got[0] : '0;
    r1 = (got.size() > 1) ? got[1] : '0;
    checks++;
    if (got.size() != 2) begin errors++; $display("FAIL mode3_records got %0d want 2", got.size()); end
    checks++;
    if (rec_ir(r0) !== 16'h6001 || rec_ir(r1) !== 16'h6ABC) begin errors++; $display("FAIL mode3_irs got %h,%h want 6001,6abc", rec_ir(r0), rec_ir(r1)); end
  endtask

  task automatic test_overflow();
    logic [REC_W-1:0] r;
    logic [DATA_W-1:0] want;
    idle_inputs();
    do_reset();
    cfg_mode = 2'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      IR = DATA_W'(i);
      cycle();
    end
    checks++;
    if (count !== CNT_W'(8)) begin errors++; $display("FAIL ovf_count got %0d want 8", count); end
    checks++;
    if (overflow_cnt !== 8'd2) begin errors++; $display("FAIL ovf_drops got %0d want 2", overflow_cnt); end
    checks++;
    if (rec_ir(out_record) !== 16'h0000 || rec_ts(out_record) !== 16'd0) begin errors++; $display("FAIL ovf_head got ir %h ts %0d want ir 0000 ts 0", rec_ir(out_record), rec_ts(out_record)); end
    out_ready = 1'b1;
    IR        = 16'h0100;
    cycle();
    checks++;
    if (count !== CNT_W'(8) || overflow_cnt !== 8'd2) begin errors++; $display("FAIL full_push_pop got count %0d ovf %0d want 8 2", count, overflow_cnt); end
    checks++;
    if (rec_ir(out_record) !== 16'h0001) begin errors++; $display("FAIL full_push_pop_head got %h want 0001", rec_ir(out_record)); end
    in_valid = 1'b0;
    got.delete();
    repeat (8) cycle();
    for (int i = 0; i < 8; i++) begin
      r    = (i < got.size()) ? got[i] : '0;
      want = (i < 7) ? DATA_W'(i + 1) : 16'h0100;
      checks++;
      if (rec_ir(r) !== want) begin errors++; $display("FAIL ovf_drain[%0d] got %h want %h", i, rec_ir(r), want); end
    end
    checks++;
    if (count !== '0) begin errors++; $display("FAIL ovf_drained_count got %0d want 0", count); end
  endtask

  task automatic test_saturate_clear();
    idle_inputs();
    do_reset();
    cfg_mode = 2'd1;
    in_valid = 1'b1;
    IR       = 16'h4242;
    repeat (DEPTH + 300) cycle();
    checks++;
    if (overflow_cnt !== 8'd255) begin errors++; $display("FAIL saturate got %0d want 255", overflow_cnt); end
    in_valid = 1'b0;
    clear    = 1'b1;
    cycle();
    clear = 1'b0;
    checks++;
    if (count !== '0 || overflow_cnt !== 8'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL clear got count %0d ovf %0d valid %0b want 0 0 0", count, overflow_cnt, out_valid); end
    cfg_mode = 2'd2;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    checks++;
    if (count !== CNT_W'(1)) begin errors++; $display("FAIL clear_mode2_capture got count %0d want 1", count); end
    checks++;
    if (rec_ts(out_record) !== 16'd0 || rec_ir(out_record) !== 16'h4242) begin errors++; $display("FAIL clear_ts got ts %0d ir %h want ts 0 ir 4242", rec_ts(out_record), rec_ir(out_record)); end
  endtask

  task automatic test_reset_midway();
    idle_inputs();
    do_reset();
    cfg_mode = 2'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      IR = DATA_W'($urandom);
      cycle();
    end
    checks++;
    if (count !== CNT_W'(4)) begin errors++; $display("FAIL midreset_fill got %0d want 4", count); end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || count !== '0 || overflow_cnt !== 8'd0) begin errors++; $display("FAIL midreset_async got valid %0b count %0d ovf %0d want 0 0 0", out_valid, count, overflow_cnt); end
    checks++;
    if (out_record !== '0) begin errors++; $display("FAIL midreset_record got %h want 0", out_record); end
    do_reset();
    IR = 16'hBEEF;
    cycle();
    in_valid = 1'b0;
    checks++;
    if (count !== CNT_W'(1) || rec_ts(out_record) !== 16'd0) begin errors++; $display("FAIL midreset_restart got count %0d ts %0d want 1 0", count, rec_ts(out_record)); end
  endtask

  task automatic test_random();
    logic [REC_W-1:0] want;
    idle_inputs();
    do_reset();
    cfg_opcode = 4'h6;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) cfg_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) cfg_opcode = 4'($urandom_range(5, 7));
      if ($urandom_range(0, 1) == 0) begin
        W_control   = 2'($urandom);
        Mem_control = 1'($urandom);
        E_control   = 6'($urandom_range(0, 1));
        IR          = {4'($urandom_range(5, 7)), 12'($urandom_range(0, 3))};
        npc_out     = 16'($urandom_range(0, 1));
      end
      in_valid  = ($urandom_range(0, 4) != 0);
      out_ready = (((i / 200) % 2) == 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 9);
      clear     = ($urandom_range(0, 63) == 0);
      cycle();
      want = (m_q.size() != 0) ? m_q[0] : '0;
      checks++;
      if (count !== CNT_W'(m_q.size())) begin errors++; $display("FAIL rand_count cyc %0d got %0d want %0d", i, count, m_q.size()); end
      checks++;
      if (int'(overflow_cnt) != m_ovf) begin errors++; $display("FAIL rand_overflow cyc %0d got %0d want %0d", i, overflow_cnt, m_ovf); end
      checks++;
      if (out_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rand_valid cyc %0d got %0b want %0b", i, out_valid, m_q.size() != 0); end
      checks++;
      if (out_record !== want) begin errors++; $display("FAIL rand_record cyc %0d got %h want %h", i, out_record, want); end
      got.delete();
    end
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_mode_all();
    test_mode_change();
    test_mode_match();
    test_overflow();
    test_saturate_clear();
    test_reset_midway();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
